xbar_rr_scheduler: RTL and testbench
====================================

# xbar_rr_scheduler

Priority scheduler for the request side of the variable-latency full-duplex crossbar. It produces the external round-robin priority vector (`req_rr_i` of the crossbar, with `ExtPrio = 1`). Each target's priority advances past the initiator that was just served, and a per-initiator starvation watchdog forces priority to any initiator stalled for `MaxWait` cycles. It sits beside the crossbar and only observes the initiator-side and target-side handshakes; it never gates them.

## Interface
- `NumIn`, 4, number of initiators (≥1)
- `NumOut`, 4, number of targets (≥1)
- `MaxWait`, 16, consecutive stalled cycles before an initiator is starving (≥1)
- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset; asynchronous and active-low
- `ini_valid_i`  in  NumIn  initiator request valid (observed)
- `ini_ready_i`  in  NumIn  initiator request ready (observed)
- `ini_tgt_addr_i`  in  NumIn×$clog2(NumOut)  initiator target address (observed)
- `tgt_valid_i`  in  NumOut  target-side request valid (observed)
- `tgt_ready_i`  in  NumOut  target-side request ready (observed)
- `tgt_ini_addr_i`  in  NumOut×$clog2(NumIn)  winning initiator at each target (observed)
- `rr_o`  out  NumOut×$clog2(NumIn)  highest-priority initiator per target; connects to the crossbar's `req_rr_i`
- `starve_o`  out  NumIn  initiator is currently starving

## Operation
- Initiator handshake: `ihs[i] = ini_valid_i[i] & ini_ready_i[i]`. Target handshake: `ths[t] = tgt_valid_i[t] & tgt_ready_i[t]`.
- Wait counter `cnt[i]` has width $clog2(MaxWait+1).
  - Cleared when `ihs[i]` or `!ini_valid_i[i]`.
  - Otherwise increments and saturates at MaxWait.
  - It does not clear if `ini_tgt_addr_i` changes while valid.
- `starve_o[i] = (cnt[i] == MaxWait)`. This is decoded combinationally from the register.
- Eligible starving set: `s[i] = starve_o[i] & ~ihs[i]`. An initiator that completes its handshake this cycle is excluded immediately.
- Next `rr_o[t]`, in priority order:
  1. If any `s[i]` with `ini_tgt_addr_i[i] == t`: the lowest such index i (override).
  2. Else if `ths[t]`: `(tgt_ini_addr_i[t] + 1)` mod NumIn. An explicit wrap is required; NumIn need not be a power of two, so the result is never ≥ NumIn.
  3. Else: hold.
- `rr_o` is registered. There is no combinational path from any input to any output except the `starve_o` decode of the register. This prevents a loop through the crossbar arbiter.
- Targets are independent. An initiator that is starving toward target t does not affect `rr_o` for any other target.
- When NumIn == 1, `rr_o` is constant 0 (zero-width indices are handled as 1 bit tied to 0).

## Timing
- Reset (async assert, sync release via flops): all `rr_o` = 0, all `cnt` = 0, `starve_o` = 0.
- A target handshake in cycle n updates `rr_o` in cycle n+1.
- An initiator stalled (valid & !ready) in cycles n … n+MaxWait−1 has `starve_o` high from cycle n+MaxWait. The `rr_o` override is visible from cycle n+MaxWait+1.
- The override holds every cycle while the initiator stays starving and unserved. In the cycle after its handshake, normal round-robin resumes from the served index +1, or the next starving initiator takes the override.
- Simultaneous override and target handshake on the same target: the override wins.
- If valid drops mid-wait, `cnt` returns to 0 next cycle and `starve_o` deasserts next cycle.
- Reset asserted mid-operation: outputs return to reset values immediately (asynchronous).

## Configuration
- Macro `XBAR_RR_SCHED_STARVE_EN`.
- Defined: watchdog as above.
- Undefined:
  - No wait counters are instantiated.
  - `starve_o` is tied to 0 and `MaxWait` is ignored.
  - `rr_o` follows only rules 2 and 3 (pure round-robin).

## Test plan
- Reset, then idle for 10 cycles -> `rr_o` all 0, `starve_o` all 0.
- NumIn=4: handshake at target 2 with `tgt_ini_addr_i[2]=3` -> next cycle `rr_o[2]=0` (wrap). Then winner 1 -> `rr_o[2]=2`. Other targets stay 0.
- NumIn=3, winner 2 -> `rr_o = 0`; check no value 3 ever appears on any target over a random run.
- MaxWait=4: initiator 1 valid toward target 0 with ready low for 4 cycles -> `starve_o[1]` high at cycle 4 and `rr_o[0]=1` at cycle 5. Meanwhile target 0 handshakes with winner 3 -> override still 1. Serve initiator 1 -> `starve_o[1]` low and `rr_o[0]=2` next cycle.
- Initiators 1 and 3 both starving toward target 0 -> `rr_o[0]=1`; after 1 is served -> `rr_o[0]=3`.
- Macro undefined: repeat the starvation scenario -> `starve_o` stays 0 and `rr_o[0]` follows only handshakes.

Source files
------------

// File: rtl/xbar_rr_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : xbar_rr_scheduler
// Purpose  : Request-side priority scheduler for the variable-latency
//            full-duplex crossbar. It produces the external round-robin
//            priority vector for the crossbar's req_rr_i input. The
//            crossbar must use its external-priority mode.
//            - Each target's priority pointer advances past the initiator
//              that was just served at that target.
//            - An optional per-initiator starvation watchdog forces the
//              pointer of the addressed target to any initiator that has
//              been stalled for MAX_WAIT consecutive cycles.
//            The block only observes handshakes and never gates them.
// Config   : `XBAR_RR_SCHED_STARVE_EN
//              defined   - wait counters and starvation override present
//              undefined - pure round-robin; starve_o tied to 0 and
//                          MAX_WAIT ignored
// Params   : NUM_IN  - number of initiators (>= 1)
//            NUM_OUT - number of targets (>= 1)
//            MAX_WAIT- consecutive stalled cycles before starving (>= 1)
// Ports    : clk_i          in   clock
//            rst_ni         in   asynchronous active-low reset
//            ini_valid_i    in   [NUM_IN]          initiator valid
//            ini_ready_i    in   [NUM_IN]          initiator ready
//            ini_tgt_addr_i in   [NUM_IN x TW]     initiator target address
//            tgt_valid_i    in   [NUM_OUT]         target-side valid
//            tgt_ready_i    in   [NUM_OUT]         target-side ready
//            tgt_ini_addr_i in   [NUM_OUT x IW]    winning initiator per target
//            rr_o           out  [NUM_OUT x IW]    priority initiator per target
//            starve_o       out  [NUM_IN]          initiator is starving
//            (IW/TW are the index widths, minimum 1 bit)
// Revision : 1.0 - initial release
// ============================================================================
module xbar_rr_scheduler #(
   parameter int NUM_IN   = 4,
   parameter int NUM_OUT  = 4,
   parameter int MAX_WAIT = 16
) (
   input  logic                                          clk_i,
   input  logic                                          rst_ni,
   input  logic [NUM_IN-1:0]                             ini_valid_i,
   input  logic [NUM_IN-1:0]                             ini_ready_i,
   input  logic [NUM_IN*((NUM_OUT > 1) ? $clog2(NUM_OUT) : 1)-1:0] ini_tgt_addr_i,
   input  logic [NUM_OUT-1:0]                            tgt_valid_i,
   input  logic [NUM_OUT-1:0]                            tgt_ready_i,
   input  logic [NUM_OUT*((NUM_IN > 1) ? $clog2(NUM_IN) : 1)-1:0]  tgt_ini_addr_i,
   output logic [NUM_OUT*((NUM_IN > 1) ? $clog2(NUM_IN) : 1)-1:0]  rr_o,
   output logic [NUM_IN-1:0]                             starve_o
);

   // Index widths; a single initiator/target still gets a 1-bit index.
   localparam int c_iw    = (NUM_IN  > 1) ? $clog2(NUM_IN)  : 1;
   localparam int c_tw    = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
   localparam int c_cnt_w = $clog2(MAX_WAIT + 1);
   localparam logic [c_cnt_w-1:0] c_max_wait = c_cnt_w'(MAX_WAIT);
   localparam logic [c_iw:0]      c_num_in   = (c_iw+1)'(NUM_IN);

   // Packed views of the flattened address buses.
   logic [NUM_IN-1:0][c_tw-1:0]  w_ini_tgt;
   logic [NUM_OUT-1:0][c_iw-1:0] w_tgt_ini;
   logic [NUM_IN-1:0]            w_ihs;
   logic [NUM_OUT-1:0]           w_ths;
   logic [NUM_IN-1:0]            w_elig;
   logic [NUM_OUT-1:0][c_iw-1:0] w_rr_nxt;
   logic [NUM_OUT-1:0][c_iw-1:0] r_rr;

   assign w_ini_tgt = ini_tgt_addr_i;
   assign w_tgt_ini = tgt_ini_addr_i;
   assign w_ihs     = ini_valid_i & ini_ready_i;
   assign w_ths     = tgt_valid_i & tgt_ready_i;

`ifdef XBAR_RR_SCHED_STARVE_EN
   // ------------------------------------------------------------------
   // Starvation watchdog: one saturating wait counter per initiator.
   // A change of target address while valid does not restart the wait;
   // the override simply follows the current address.
   // ------------------------------------------------------------------
   logic [c_cnt_w-1:0] r_cnt [NUM_IN];

   for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_wait_cnt
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            r_cnt[gi] <= '0;
         end else if (w_ihs[gi] || !ini_valid_i[gi]) begin
            r_cnt[gi] <= '0;
         end else if (r_cnt[gi] != c_max_wait) begin
            r_cnt[gi] <= r_cnt[gi] + c_cnt_w'(1);
         end
      end

      assign starve_o[gi] = (r_cnt[gi] == c_max_wait);
   end

   // An initiator served this cycle no longer needs the override.
   assign w_elig = starve_o & ~w_ihs;
`else
   // Pure round-robin build: the initiator handshake is not needed.
   logic w_unused_cfg;

   assign starve_o     = '0;
   assign w_elig       = '0;
   assign w_unused_cfg = ^{ini_valid_i, ini_ready_i, ini_tgt_addr_i,
                           c_max_wait, w_ihs, w_elig, w_ini_tgt};
`endif

   // ------------------------------------------------------------------
   // Next priority pointer per target.
   // Priority: starving override (lowest index) > handshake advance > hold.
   // ------------------------------------------------------------------
   always_comb begin
      logic [c_iw:0] v_inc;
      w_rr_nxt = r_rr;
      v_inc    = '0;
      for (int t = 0; t < NUM_OUT; t++) begin
         if (w_ths[t]) begin
            // Explicit modulo: NUM_IN need not be a power of two.
            v_inc = {1'b0, w_tgt_ini[t]} + (c_iw+1)'(1);
            if (v_inc >= c_num_in) begin
               v_inc = v_inc - c_num_in;
            end
            w_rr_nxt[t] = v_inc[c_iw-1:0];
         end
`ifdef XBAR_RR_SCHED_STARVE_EN
         // Walk downward so the lowest eligible index is written last.
         for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (w_elig[i] && (w_ini_tgt[i] == c_tw'(t))) begin
               w_rr_nxt[t] = c_iw'(i);
            end
         end
`endif
         if (NUM_IN == 1) begin
            w_rr_nxt[t] = '0;
         end
      end
   end

   // Registered pointers: no combinational path back into the arbiter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rr <= '0;
      end else begin
         r_rr <= w_rr_nxt;
      end
   end

   assign rr_o = r_rr;

endmodule
`default_nettype wire

// File: tb/tb_xbar_rr_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_xbar_rr_scheduler
// Purpose  : Directed bench for xbar_rr_scheduler. Instance u_dut4 uses
//            NUM_IN=4, NUM_OUT=4, MAX_WAIT=4; instance u_dut3 uses NUM_IN=3
//            to exercise the non-power-of-two wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xbar_rr_scheduler;

   logic       clk;
   logic       rst_n;

   // NUM_IN=4 instance
   logic [3:0] ini_valid, ini_ready;
   logic [7:0] ini_tgt_addr;
   logic [3:0] tgt_valid, tgt_ready;
   logic [7:0] tgt_ini_addr;
   logic [7:0] rr;
   logic [3:0] starve;

   // NUM_IN=3 instance
   logic [2:0] ini_valid3, ini_ready3;
   logic [5:0] ini_tgt_addr3;
   logic [3:0] tgt_valid3, tgt_ready3;
   logic [7:0] tgt_ini_addr3;
   logic [7:0] rr3;
   logic [2:0] starve3;

   int n_tests = 0;
   int n_fail  = 0;

   xbar_rr_scheduler #(.NUM_IN(4), .NUM_OUT(4), .MAX_WAIT(4)) u_dut4 (
      .clk_i(clk), .rst_ni(rst_n),
      .ini_valid_i(ini_valid), .ini_ready_i(ini_ready),
      .ini_tgt_addr_i(ini_tgt_addr),
      .tgt_valid_i(tgt_valid), .tgt_ready_i(tgt_ready),
      .tgt_ini_addr_i(tgt_ini_addr),
      .rr_o(rr), .starve_o(starve)
   );

   xbar_rr_scheduler #(.NUM_IN(3), .NUM_OUT(4), .MAX_WAIT(4)) u_dut3 (
      .clk_i(clk), .rst_ni(rst_n),
      .ini_valid_i(ini_valid3), .ini_ready_i(ini_ready3),
      .ini_tgt_addr_i(ini_tgt_addr3),
      .tgt_valid_i(tgt_valid3), .tgt_ready_i(tgt_ready3),
      .tgt_ini_addr_i(tgt_ini_addr3),
      .rr_o(rr3), .starve_o(starve3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached, required finish");
      $fatal(1, "timeout");
   end

   // One clock edge, then settle; inputs change and outputs are sampled here.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ini_valid = '0; ini_ready = '0; ini_tgt_addr = '0;
      tgt_valid = '0; tgt_ready = '0; tgt_ini_addr = '0;
      ini_valid3 = '0; ini_ready3 = '0; ini_tgt_addr3 = '0;
      tgt_valid3 = '0; tgt_ready3 = '0; tgt_ini_addr3 = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic tgt_hs(input int t, input int w);
      tgt_valid[t] = 1'b1;
      tgt_ready[t] = 1'b1;
      tgt_ini_addr[t*2 +: 2] = 2'(w);
   endtask

   task automatic tgt_hs3(input int t, input int w);
      tgt_valid3[t] = 1'b1;
      tgt_ready3[t] = 1'b1;
      tgt_ini_addr3[t*2 +: 2] = 2'(w);
   endtask

   task automatic test_reset();
      do_reset();
      for (int k = 0; k < 10; k++) begin
         step();
         n_tests++;
         if (rr !== 8'h00 || starve !== 4'h0 || rr3 !== 8'h00 || starve3 !== 3'h0) begin
            $display("FAIL reset_idle cyc %0d: rr=%h starve=%b rr3=%h starve3=%b, required all 0",
                     k, rr, starve, rr3, starve3);
            n_fail++;
         end
      end
   endtask

   task automatic test_rr_wrap();
      do_reset();
      tgt_hs(2, 1); step();
      n_tests++;
      if (rr !== 8'h20) begin
         $display("FAIL rr_adv1: rr=%h, required 20", rr); n_fail++;
      end
      tgt_hs(2, 3); step();
      n_tests++;
      if (rr !== 8'h00) begin
         $display("FAIL rr_wrap4: rr=%h, required 00", rr); n_fail++;
      end
      tgt_hs(2, 1); step();
      n_tests++;
      if (rr !== 8'h20) begin
         $display("FAIL rr_adv2: rr=%h, required 20", rr); n_fail++;
      end
      tgt_valid = '0; step();
      n_tests++;
      if (rr !== 8'h20) begin
         $display("FAIL rr_hold_idle: rr=%h, required 20", rr); n_fail++;
      end
      tgt_valid = 4'hF; tgt_ready = '0; step();
      n_tests++;
      if (rr !== 8'h20) begin
         $display("FAIL rr_hold_noready: rr=%h, required 20", rr); n_fail++;
      end
      tgt_valid = '0; tgt_ready = '0;
      tgt_hs(0, 0); tgt_hs(3, 2); step();
      n_tests++;
      if (rr !== 8'hE1) begin
         $display("FAIL rr_multi_tgt: rr=%h, required E1", rr); n_fail++;
      end
      clear_inputs();
   endtask

   task automatic test_nonpow2();
      logic [1:0] m [4];
      logic [7:0] m_flat;
      do_reset();
      tgt_hs3(0, 0); step();
      n_tests++;
      if (rr3[1:0] !== 2'd1) begin
         $display("FAIL n3_adv0: rr3[0]=%0d, required 1", rr3[1:0]); n_fail++;
      end
      tgt_hs3(0, 1); step();
      n_tests++;
      if (rr3[1:0] !== 2'd2) begin
         $display("FAIL n3_adv1: rr3[0]=%0d, required 2", rr3[1:0]); n_fail++;
      end
      tgt_hs3(0, 2); step();
      n_tests++;
      if (rr3 !== 8'h00) begin
         $display("FAIL n3_wrap: rr3=%h, required 00", rr3); n_fail++;
      end
      for (int t = 0; t < 4; t++) m[t] = 2'd0;
      for (int k = 0; k < 120; k++) begin
         for (int t = 0; t < 4; t++) begin
            tgt_valid3[t] = 1'($urandom_range(0, 1));
            tgt_ready3[t] = 1'($urandom_range(0, 1));
            tgt_ini_addr3[t*2 +: 2] = 2'($urandom_range(0, 2));
            if (tgt_valid3[t] && tgt_ready3[t])
               m[t] = 2'((int'(tgt_ini_addr3[t*2 +: 2]) + 1) % 3);
         end
         step();
         m_flat = {m[3], m[2], m[1], m[0]};
         n_tests++;
         if (rr3 !== m_flat) begin
            $display("FAIL n3_random cyc %0d: rr3=%h, required %h", k, rr3, m_flat); n_fail++;
         end
         for (int t = 0; t < 4; t++) begin
            n_tests++;
            if (rr3[t*2 +: 2] === 2'd3 || $isunknown(rr3[t*2 +: 2])) begin
               $display("FAIL n3_range cyc %0d tgt %0d: rr3=%0d, required < 3", k, t, rr3[t*2 +: 2]);
               n_fail++;
            end
         end
      end
      clear_inputs();
   endtask

   task automatic test_async_reset();
      do_reset();
      tgt_hs(1, 2); step();
      n_tests++;
      if (rr !== 8'h0C) begin
         $display("FAIL areset_pre: rr=%h, required 0C", rr); n_fail++;
      end
      tgt_valid = '0; tgt_ready = '0;
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (rr !== 8'h00 || starve !== 4'h0) begin
         $display("FAIL areset_async: rr=%h starve=%b, required 00/0000", rr, starve); n_fail++;
      end
      clear_inputs();
      step();
      rst_n = 1'b1;
      step();
   endtask

`ifdef XBAR_RR_SCHED_STARVE_EN
   task automatic test_starve();
      do_reset();
      ini_valid[1] = 1'b1; ini_ready[1] = 1'b0; ini_tgt_addr[3:2] = 2'd0;
      for (int k = 1; k <= 3; k++) begin
         step();
         n_tests++;
         if (starve !== 4'h0) begin
            $display("FAIL starve_early cyc %0d: starve=%b, required 0000", k, starve); n_fail++;
         end
      end
      step();
      n_tests++;
      if (starve !== 4'b0010 || rr !== 8'h00) begin
         $display("FAIL starve_on: starve=%b rr=%h, required 0010/00", starve, rr); n_fail++;
      end
      tgt_hs(0, 3); step();
      n_tests++;
      if (rr !== 8'h01 || starve !== 4'b0010) begin
         $display("FAIL starve_override: rr=%h starve=%b, required 01/0010", rr, starve); n_fail++;
      end
      step();
      n_tests++;
      if (rr !== 8'h01) begin
         $display("FAIL starve_hold: rr=%h, required 01", rr); n_fail++;
      end
      tgt_hs(0, 1); ini_ready[1] = 1'b1; step();
      n_tests++;
      if (rr !== 8'h02 || starve !== 4'h0) begin
         $display("FAIL starve_served: rr=%h starve=%b, required 02/0000", rr, starve); n_fail++;
      end
      clear_inputs();
   endtask

   task automatic test_two_starve();
      do_reset();
      ini_valid = 4'b1110; ini_ready = '0; ini_tgt_addr = 8'h10;
      for (int k = 0; k < 4; k++) step();
      n_tests++;
      if (starve !== 4'b1110) begin
         $display("FAIL two_starve_on: starve=%b, required 1110", starve); n_fail++;
      end
      step();
      n_tests++;
      if (rr !== 8'h09) begin
         $display("FAIL two_starve_low: rr=%h, required 09", rr); n_fail++;
      end
      ini_ready[1] = 1'b1; tgt_hs(0, 1); step();
      n_tests++;
      if (rr !== 8'h0B || starve !== 4'b1100) begin
         $display("FAIL two_starve_next: rr=%h starve=%b, required 0B/1100", rr, starve); n_fail++;
      end
      ini_valid[1] = 1'b0; ini_ready[1] = 1'b0; ini_ready[3] = 1'b1; tgt_hs(0, 3); step();
      n_tests++;
      if (rr !== 8'h08 || starve !== 4'b0100) begin
         $display("FAIL two_starve_resume: rr=%h starve=%b, required 08/0100", rr, starve); n_fail++;
      end
      clear_inputs();
   endtask

   task automatic test_addr_change();
      do_reset();
      ini_valid[2] = 1'b1; ini_tgt_addr = 8'h00;
      step(); step();
      ini_tgt_addr = 8'h30;
      step(); step();
      n_tests++;
      if (starve !== 4'b0100) begin
         $display("FAIL addr_change_starve: starve=%b, required 0100", starve); n_fail++;
      end
      step();
      n_tests++;
      if (rr !== 8'h80) begin
         $display("FAIL addr_change_rr: rr=%h, required 80", rr); n_fail++;
      end
      clear_inputs();
   endtask

   task automatic test_valid_drop();
      do_reset();
      ini_valid[0] = 1'b1;
      step(); step(); step();
      ini_valid[0] = 1'b0; step();
      ini_valid[0] = 1'b1;
      step(); step(); step();
      n_tests++;
      if (starve !== 4'h0) begin
         $display("FAIL drop_restart: starve=%b, required 0000", starve); n_fail++;
      end
      step();
      n_tests++;
      if (starve !== 4'b0001) begin
         $display("FAIL drop_then_starve: starve=%b, required 0001", starve); n_fail++;
      end
      ini_valid[0] = 1'b0; step();
      n_tests++;
      if (starve !== 4'h0) begin
         $display("FAIL drop_deassert: starve=%b, required 0000", starve); n_fail++;
      end
      clear_inputs();
   endtask
`else
   task automatic test_pure_rr();
      do_reset();
      ini_valid[1] = 1'b1; ini_ready[1] = 1'b0; ini_tgt_addr = 8'h00;
      for (int k = 0; k < 6; k++) begin
         step();
         n_tests++;
         if (starve !== 4'h0 || rr !== 8'h00) begin
            $display("FAIL pure_no_starve cyc %0d: starve=%b rr=%h, required 0000/00", k, starve, rr);
            n_fail++;
         end
      end
      tgt_hs(0, 2); step();
      n_tests++;
      if (rr !== 8'h03) begin
         $display("FAIL pure_rr_adv: rr=%h, required 03", rr); n_fail++;
      end
      tgt_hs(0, 3); step();
      n_tests++;
      if (rr !== 8'h00 || starve !== 4'h0) begin
         $display("FAIL pure_rr_wrap: rr=%h starve=%b, required 00/0000", rr, starve); n_fail++;
      end
      clear_inputs();
   endtask
`endif

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      test_reset();
      test_rr_wrap();
      test_nonpow2();
      test_async_reset();
`ifdef XBAR_RR_SCHED_STARVE_EN
      test_starve();
      test_two_starve();
      test_addr_change();
      test_valid_drop();
`else
      test_pure_rr();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
